// File: rtl/window_3x3_gen_if.sv
// window_3x3_gen_if: pixel-in / window-out bundle for window_3x3_gen.
// master = upstream driver + downstream consumer side, slave = the generator.
interface window_3x3_gen_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                      valid_in;
  logic [DATA_WIDTH-1:0]     data_in;
  logic                      valid_out;
  logic [9*DATA_WIDTH-1:0]   window_out;
  logic                      done;
  logic                      overrun;

  modport master (
    output valid_in,
    output data_in,
    input  valid_out,
    input  window_out,
    input  done,
    input  overrun
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output valid_out,
    output window_out,
    output done,
    output overrun
  );
endinterface

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator with 1-pixel zero
// padding ("same" output size). Two WIDTH-deep line buffers plus a 3x3
// register window; out-of-map taps are zeroed by masking at the output.
// Optional feature: define WIN3X3_OVERRUN_EN to build the sticky overrun flag
// (otherwise overrun is tied low and dropped pixels vanish silently).
module window_3x3_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 4,
  parameter int HEIGHT     = 4
) (
  input logic             clk,
  input logic             resetn,
  window_3x3_gen_if.slave bus
);

  localparam int CW = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_ONE    = CW'(1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_PENULT = RW'(HEIGHT - 2);
  localparam logic [RW-1:0] ROW_ONE    = RW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_PADCOL = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;

  logic [2:0]              state_reg, state_next;
  logic [CW-1:0]           col_reg;
  logic [RW-1:0]           row_reg;
  logic [CW-1:0]           fc_reg;       // column of the bottom-row window in FLUSH
  logic [RW-1:0]           win_row_reg;  // centre row of the most recent streamed window
  logic [CW-1:0]           fc_left, fc_right;

  logic [DATA_WIDTH-1:0]   lb_top [WIDTH];  // row above the row being received
  logic [DATA_WIDTH-1:0]   lb_mid [WIDTH];  // row being received (older columns: previous row)
  logic [DATA_WIDTH-1:0]   win_reg  [3][3];
  logic [DATA_WIDTH-1:0]   win_next [3][3];
  logic [DATA_WIDTH-1:0]   tap_raw  [9];
  logic [8:0]              tap_keep;
  logic                    top_ok, bot_ok, left_ok, right_ok;

  logic                    accept, emit_stream, emit_pad, emit_flush, emit;
  logic                    valid_out_reg, done_reg;
  logic [9*DATA_WIDTH-1:0] window_out_reg, window_masked;

  assign accept = bus.valid_in &&
                  (state_reg == S_IDLE || state_reg == S_FILL || state_reg == S_STREAM);
  assign emit_stream = accept && (state_reg == S_STREAM) && (col_reg != '0);
  assign emit_pad    = (state_reg == S_PADCOL);
  assign emit_flush  = (state_reg == S_FLUSH);
  assign emit        = emit_stream || emit_pad || emit_flush;

  // Neighbour columns for the FLUSH read; clamped at the edges (those taps are masked).
  assign fc_left  = (fc_reg == '0)       ? '0       : fc_reg - COL_ONE;
  assign fc_right = (fc_reg == COL_LAST) ? COL_LAST : fc_reg + COL_ONE;

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.valid_in) state_next = S_FILL;
      S_FILL:   if (bus.valid_in && row_reg == ROW_ONE && col_reg == '0) state_next = S_STREAM;
      S_STREAM: if (bus.valid_in && col_reg == COL_LAST) state_next = S_PADCOL;
      S_PADCOL: state_next = (win_row_reg == ROW_PENULT) ? S_FLUSH : S_STREAM;
      S_FLUSH:  if (fc_reg == COL_LAST) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Window shift: accepted column enters on the right; PADCOL shifts with the right column left stale.
  always_comb begin
    win_next = win_reg;
    if (accept || state_reg == S_PADCOL) begin
      for (int dr = 0; dr < 3; dr++) begin
        win_next[dr][0] = win_reg[dr][1];
        win_next[dr][1] = win_reg[dr][2];
      end
    end
    if (accept) begin
      win_next[0][2] = lb_top[col_reg];
      win_next[1][2] = lb_mid[col_reg];
      win_next[2][2] = bus.data_in;
    end
  end

  // Tap sources and border masks for the window being emitted this cycle.
  always_comb begin
    top_ok   = 1'b1;
    bot_ok   = 1'b1;
    left_ok  = 1'b1;
    right_ok = 1'b1;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        tap_raw[3*dr+dc] = win_next[dr][dc];
      end
    end
    case (state_reg)
      S_STREAM: begin
        top_ok  = (row_reg != ROW_ONE);
        left_ok = (col_reg != COL_ONE);
      end
      S_PADCOL: begin
        top_ok   = (win_row_reg != '0);
        right_ok = 1'b0;
      end
      S_FLUSH: begin
        bot_ok   = 1'b0;
        left_ok  = (fc_reg != '0);
        right_ok = (fc_reg != COL_LAST);
        tap_raw[0] = lb_top[fc_left];
        tap_raw[1] = lb_top[fc_reg];
        tap_raw[2] = lb_top[fc_right];
        tap_raw[3] = lb_mid[fc_left];
        tap_raw[4] = lb_mid[fc_reg];
        tap_raw[5] = lb_mid[fc_right];
        tap_raw[6] = '0;
        tap_raw[7] = '0;
        tap_raw[8] = '0;
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_tap
      localparam int DR = gi / 3;
      localparam int DC = gi % 3;
      assign tap_keep[gi] = ((DR != 0) || top_ok)  && ((DR != 2) || bot_ok) &&
                            ((DC != 0) || left_ok) && ((DC != 2) || right_ok);
      assign window_masked[gi*DATA_WIDTH +: DATA_WIDTH] = tap_keep[gi] ? tap_raw[gi] : '0;
    end
  endgenerate

  // Line buffers: in-place column update, old row moves up, new pixel lands in the middle row.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col_reg] <= lb_mid[col_reg];
      lb_mid[col_reg] <= bus.data_in;
    end
  end

  // Window registers carry pure data; stale contents are always masked away.
  always_ff @(posedge clk) begin
    win_reg <= win_next;
  end

  // Sequencer, pixel counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      fc_reg         <= '0;
      win_row_reg    <= '0;
      valid_out_reg  <= 1'b0;
      done_reg       <= 1'b0;
      window_out_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        if (col_reg == COL_LAST) begin
          col_reg <= '0;
          row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + ROW_ONE;
        end else begin
          col_reg <= col_reg + COL_ONE;
        end
      end
      if (emit_stream) win_row_reg <= row_reg - ROW_ONE;
      if (emit_flush)  fc_reg <= (fc_reg == COL_LAST) ? '0 : fc_reg + COL_ONE;
      valid_out_reg <= emit;
      done_reg      <= emit_flush && (fc_reg == COL_LAST);
      if (emit) window_out_reg <= window_masked;
    end
  end

  assign bus.valid_out  = valid_out_reg;
  assign bus.window_out = window_out_reg;
  assign bus.done       = done_reg;

`ifdef WIN3X3_OVERRUN_EN
  logic overrun_reg;

  // Sticky flag: a pixel offered while the generator cannot take input is lost.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun_reg <= 1'b0;
    end else if (bus.valid_in && (state_reg == S_PADCOL || state_reg == S_FLUSH)) begin
      overrun_reg <= 1'b1;
    end
  end

  assign bus.overrun = overrun_reg;
`else
  assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: scoreboard bench for window_3x3_gen (4x4 and 2x2 instances).
// Drivers push expected windows with their due cycle; monitors pop and compare.
module tb_window_3x3_gen;
  localparam int DW = 32;
  localparam int WW = 9 * DW;
`ifdef WIN3X3_OVERRUN_EN
  localparam int EXP_OVR = 1;
`else
  localparam int EXP_OVR = 0;
`endif

  typedef struct {
    logic [WW-1:0] win;
    int            done;
    int            cyc;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t          q4[$];
  exp_t          q2[$];
  logic [WW-1:0] got4[$];
  logic [WW-1:0] got2[$];
  int r4 = 0, c4 = 0, base4 = 0;
  int r2 = 0, c2 = 0, base2 = 0;
  int gaps[16] = '{1, 3, 5, 2, 1, 4, 1, 1, 5, 2, 3, 1, 4, 2, 1, 3};

  window_3x3_gen_if #(.DATA_WIDTH(DW)) bus4 ();
  window_3x3_gen_if #(.DATA_WIDTH(DW)) bus2 ();

  window_3x3_gen #(.DATA_WIDTH(DW), .WIDTH(4), .HEIGHT(4)) dut4 (
    .clk(clk), .resetn(resetn), .bus(bus4.slave));
  window_3x3_gen #(.DATA_WIDTH(DW), .WIDTH(2), .HEIGHT(2)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_win(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference window: pixel (r,c) of a frame is base + r*w + c + 1, outside the map is 0.
  function automatic logic [WW-1:0] model_win(input int base, input int r, input int c,
                                              input int w, input int h);
    logic [WW-1:0] v;
    v = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        int rr;
        int cc;
        rr = r + dr - 1;
        cc = c + dc - 1;
        if (rr >= 0 && rr < h && cc >= 0 && cc < w)
          v[(3*dr+dc)*DW +: DW] = DW'(base + rr*w + cc + 1);
      end
    end
    return v;
  endfunction

  function automatic logic [WW-1:0] pack9(input int t0, input int t1, input int t2,
                                          input int t3, input int t4, input int t5,
                                          input int t6, input int t7, input int t8);
    logic [WW-1:0] v;
    int t[9];
    t = '{t0, t1, t2, t3, t4, t5, t6, t7, t8};
    for (int k = 0; k < 9; k++) v[k*DW +: DW] = DW'(t[k]);
    return v;
  endfunction

  task automatic push_exp(input int d, input logic [WW-1:0] w, input int dn, input int c);
    exp_t e;
    e.win  = w;
    e.done = dn;
    e.cyc  = c;
    if (d == 4) q4.push_back(e);
    else        q2.push_back(e);
  endtask

  task automatic new_frame(input int d, input int base);
    if (d == 4) begin r4 = 0; c4 = 0; base4 = base; got4.delete(); end
    else        begin r2 = 0; c2 = 0; base2 = base; got2.delete(); end
  endtask

  // Offer one pixel after `gap` idle cycles and queue every window it is due to release.
  task automatic send_px(input int d, input int gap);
    int w, h, r, c, base, n;
    logic [DW-1:0] px;
    w    = (d == 4) ? 4 : 2;
    h    = w;
    r    = (d == 4) ? r4 : r2;
    c    = (d == 4) ? c4 : c2;
    base = (d == 4) ? base4 : base2;
    repeat (gap) begin @(posedge clk); #1; end
    n  = cyc + 1;
    px = DW'(base + r*w + c + 1);
    if (d == 4) begin bus4.data_in = px; bus4.valid_in = 1'b1; end
    else        begin bus2.data_in = px; bus2.valid_in = 1'b1; end
    if (r >= 1 && c >= 1) push_exp(d, model_win(base, r-1, c-1, w, h), 0, n);
    if (r >= 1 && c == w-1) begin
      push_exp(d, model_win(base, r-1, w-1, w, h), 0, n+1);
      if (r == h-1)
        for (int f = 0; f < w; f++)
          push_exp(d, model_win(base, h-1, f, w, h), (f == w-1) ? 1 : 0, n+2+f);
    end
    @(posedge clk); #1;
    if (d == 4) bus4.valid_in = 1'b0;
    else        bus2.valid_in = 1'b0;
    c++;
    if (c == w) begin c = 0; r++; if (r == h) r = 0; end
    if (d == 4) begin r4 = r; c4 = c; end
    else        begin r2 = r; c2 = c; end
  endtask

  task automatic wait_drain(input int d, input int budget);
    int left;
    left = (d == 4) ? q4.size() : q2.size();
    for (int i = 0; i < budget && left != 0; i++) begin
      @(posedge clk); #1;
      left = (d == 4) ? q4.size() : q2.size();
    end
    check_int($sformatf("drain_dut%0d_pending", d), left, 0);
  endtask

  task automatic wait_done4(input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus4.done) begin seen = 1; break; end
    end
    check_int("done4_seen", seen, 1);
  endtask

  task automatic spot(input int d, input string name, input int idx, input logic [WW-1:0] req);
    int sz;
    sz = (d == 4) ? got4.size() : got2.size();
    if (idx >= sz) begin
      checks++; errors++;
      $display("FAIL %s: got %0d windows, required index %0d", name, sz, idx);
    end else begin
      check_win(name, (d == 4) ? got4[idx] : got2[idx], req);
    end
  endtask

  task automatic take(input int d, input logic [WW-1:0] w, input int dn);
    exp_t e;
    if ((d == 4 && q4.size() == 0) || (d == 2 && q2.size() == 0)) begin
      checks++; errors++;
      $display("FAIL unexpected_window_dut%0d: got %h, required no output", d, w);
      return;
    end
    if (d == 4) begin e = q4.pop_front(); got4.push_back(w); end
    else        begin e = q2.pop_front(); got2.push_back(w); end
    $display("dut%0d window at cycle %0d done=%0d", d, cyc, dn);
    check_win($sformatf("window_dut%0d", d), w, e.win);
    check_int($sformatf("done_dut%0d", d), dn, e.done);
    check_int($sformatf("latency_dut%0d", d), cyc, e.cyc);
  endtask

  // Monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus4.valid_out) take(4, bus4.window_out, int'(bus4.done));
      else if (bus4.done) begin
        checks++; errors++;
        $display("FAIL stray_done_dut4: got 1, required 0 at cycle %0d", cyc);
      end
      if (bus2.valid_out) take(2, bus2.window_out, int'(bus2.done));
      else if (bus2.done) begin
        checks++; errors++;
        $display("FAIL stray_done_dut2: got 1, required 0 at cycle %0d", cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus4.valid_in = 1'b0; bus4.data_in = '0;
    bus2.valid_in = 1'b0; bus2.data_in = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_valid4",   int'(bus4.valid_out), 0);
    check_win("rst_window4",  bus4.window_out, '0);
    check_int("rst_done4",    int'(bus4.done), 0);
    check_int("rst_overrun4", int'(bus4.overrun), 0);
    check_int("rst_valid2",   int'(bus2.valid_out), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // 4x4 frame, one pixel every other cycle.
    new_frame(4, 0);
    for (int i = 0; i < 16; i++) send_px(4, 1);
    wait_drain(4, 40);
    spot(4, "t1_first",  0,  pack9(0,0,0, 0,1,2, 0,5,6));
    spot(4, "t1_centre", 5,  pack9(1,2,3, 5,6,7, 9,10,11));
    spot(4, "t1_r0c3",   3,  pack9(0,0,0, 3,4,0, 7,8,0));
    spot(4, "t1_r3c0",   12, pack9(0,9,10, 0,13,14, 0,0,0));
    spot(4, "t1_last",   15, pack9(11,12,0, 15,16,0, 0,0,0));
    repeat (3) @(posedge clk); #1;

    // Same frame with irregular gaps.
    new_frame(4, 0);
    for (int i = 0; i < 16; i++) send_px(4, gaps[i]);
    wait_drain(4, 40);
    spot(4, "t2_first", 0,  pack9(0,0,0, 0,1,2, 0,5,6));
    spot(4, "t2_last",  15, pack9(11,12,0, 15,16,0, 0,0,0));
    repeat (2) @(posedge clk); #1;

    // Back-to-back frames, second starts the cycle after done.
    new_frame(4, 0);
    for (int i = 0; i < 16; i++) send_px(4, 1);
    wait_done4(40);
    @(posedge clk); #1;
    r4 = 0; c4 = 0; base4 = 16;
    send_px(4, 0);
    for (int i = 1; i < 16; i++) send_px(4, 1);
    wait_drain(4, 40);
    spot(4, "t3_f2_first", 16, pack9(0,0,0, 0,17,18, 0,21,22));
    spot(4, "t3_f2_last",  31, pack9(27,28,0, 31,32,0, 0,0,0));
    repeat (2) @(posedge clk); #1;

    // Pixel offered during FLUSH is dropped; next frame must be unaffected.
    new_frame(4, 0);
    for (int i = 0; i < 16; i++) send_px(4, 1);
    @(posedge clk); #1;
    bus4.data_in = 32'hDEAD_BEEF; bus4.valid_in = 1'b1;
    @(posedge clk); #1;
    bus4.valid_in = 1'b0;
    wait_drain(4, 40);
    check_int("overrun_after_drop", int'(bus4.overrun), EXP_OVR);
    new_frame(4, 100);
    for (int i = 0; i < 16; i++) send_px(4, 1);
    wait_drain(4, 40);
    spot(4, "t4_next_first", 0, pack9(0,0,0, 0,101,102, 0,105,106));
    check_int("overrun_sticky", int'(bus4.overrun), EXP_OVR);

    // Reset after pixel 7, then a clean frame.
    new_frame(4, 0);
    for (int i = 0; i < 7; i++) send_px(4, 1);
    wait_drain(4, 10);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check_int("midrst_valid",   int'(bus4.valid_out), 0);
    check_win("midrst_window",  bus4.window_out, '0);
    check_int("midrst_overrun", int'(bus4.overrun), 0);
    new_frame(4, 0);
    for (int i = 0; i < 16; i++) send_px(4, 1);
    wait_drain(4, 40);
    check_int("t5_window_count", got4.size(), 16);
    spot(4, "t5_first", 0,  pack9(0,0,0, 0,1,2, 0,5,6));
    spot(4, "t5_last",  15, pack9(11,12,0, 15,16,0, 0,0,0));

    // 2x2 frame.
    new_frame(2, 0);
    for (int i = 0; i < 4; i++) send_px(2, 1);
    wait_drain(2, 20);
    check_int("t6_window_count", got2.size(), 4);
    spot(2, "t6_first", 0, pack9(0,0,0, 0,1,2, 0,3,4));
    spot(2, "t6_last",  3, pack9(1,2,0, 3,4,0, 0,0,0));

    repeat (3) @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Streaming 3x3 window generator with 1-pixel zero padding, placed directly downstream of `max_pooling`. It consumes the pooled feature map in raster order, one 32-bit word per `valid_in` pulse. It emits one full 3x3 neighbourhood per output pixel ("same" padding), which is the input format of the next VGG16 conv stage. Storage is two WIDTH-deep line buffers plus a 3x3 register window; no frame buffer.

## Interface
- `DATA_WIDTH`, 32: pixel word width; treated as opaque bits, zero pad = all-zero word.
- `WIDTH`, 4: pooled map columns (>= 2).
- `HEIGHT`, 4: pooled map rows (>= 2).
- `clk`  in  1  single clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `valid_in`  in  1  `data_in` valid this cycle (driven by `max_pooling` `valid_out`).
- `data_in`  in  DATA_WIDTH  pooled pixel.
- `valid_out`  out  1  `window_out` valid this cycle (one-cycle pulse per window).
- `window_out`  out  9*DATA_WIDTH  tap k = 3*dr+dc at bits [k*DATA_WIDTH +: DATA_WIDTH]; dr/dc = 0..2, top-left first, centre is k=4.
- `done`  out  1  one-cycle pulse coincident with the last window of a frame.
- `overrun`  out  1  sticky protocol-violation flag (see Configuration).

## Operation
- Counters `col` (0..WIDTH-1) and `row` (0..HEIGHT-1) track the accepted pixel; wrap col->0 with row+1, row wraps to 0 after the frame.
- Line buffers hold rows r-1 and r; accepted pixel shifts into the window's right column, buffers updated in place.
- Window centred (r,c) needs pixel (r+1, min(c+1,WIDTH-1)). Taps outside the map (r-1<0, c-1<0, c+1>=WIDTH, r+1>=HEIGHT) are forced to zero by masking, never by clearing storage.
- FSM states:
  - IDLE: no pixels held; first accepted pixel -> FILL.
  - FILL: accepting row 0; no output. Acceptance of (1,0) -> STREAM.
  - STREAM: accepted pixel (r+1,c+1) emits window (r,c). Accepted (r+1,WIDTH-1) emits (r,WIDTH-2), then -> PADCOL.
  - PADCOL: one cycle, emits (r,WIDTH-1) with right taps zeroed. -> STREAM, or -> FLUSH if r+1 == HEIGHT-1.
  - FLUSH: no input consumed; emits (HEIGHT-1, 0..WIDTH-1) one per cycle, bottom taps zeroed; `done` with the last; -> IDLE.
- Exactly WIDTH*HEIGHT windows per frame, raster order.
- `valid_in` high in PADCOL or FLUSH is a violation: pixel dropped, counters unchanged.

## Timing
- Reset values: `valid_out`=0, `window_out`=0, `done`=0, `overrun`=0, FSM=IDLE, col=row=0.
- Streamed window: `valid_out` one cycle after the accepting edge of pixel (r+1,c+1).
- PADCOL window: one cycle after (r,WIDTH-2) window.
- FLUSH: WIDTH consecutive `valid_out` cycles starting the cycle after the last PADCOL window; `done` on the final one.
- Upstream guarantee: `valid_in` never high two consecutive cycles, which `max_pooling` satisfies.
- Next frame may start the cycle after `done` (IDLE accepts immediately).
- `resetn` low mid-frame: next edge returns to reset state; partial frame discarded, no `done`.

## Configuration
- `WIN3X3_OVERRUN_EN` defined: `overrun` set on any dropped `valid_in` (PADCOL, FLUSH) and held until reset.
- Not defined: detection logic absent, `overrun` tied 0; dropped pixels are still dropped silently.

## Test plan
- 4x4 frame, pixels 1..16, `valid_in` every other cycle -> 16 windows; first = {0,0,0, 0,1,2, 0,5,6}, centre (1,1) = {1,2,3,5,6,7,9,10,11}, last = {11,12,0, 15,16,0, 0,0,0}; `done` with 16th.
- Same frame, irregular gaps of 1-5 idle cycles -> identical window sequence; each streamed window one cycle after its trigger pixel.
- Two back-to-back frames (1..16 then 17..32, first pixel the cycle after `done`) -> 32 windows, second frame's (0,0) = {0,0,0, 0,17,18, 0,21,22}, no row-1 leakage.
- `resetn` low for one cycle after pixel 7, then full frame -> no `done` for partial, clean 16 windows afterwards.
- Macro defined, `valid_in` asserted during FLUSH -> `overrun`=1 sticky, window stream unchanged; macro undefined -> `overrun` stays 0.
- WIDTH=2, HEIGHT=2, pixels 1..4 -> 4 windows, (0,0) = {0,0,0, 0,1,2, 0,3,4}, `done` on 4th.
